// File: rtl/urv_lsu.sv
// urv_lsu: load/store unit with in-order load metadata FIFO and writeback align.
// Optional misalignment trap: define URV_LSU_MISALIGN_TRAP_EN.
module urv_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OUTSTANDING = 2,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  x_req_valid_i,
    output logic                  x_req_ready_o,
    input  logic                  x_kill_i,
    input  logic                  x_is_load_i,
    input  logic                  x_is_store_i,
    input  logic [2:0]            x_fun_i,
    input  logic [ADDR_WIDTH-1:0] x_addr_i,
    input  logic [31:0]           x_data_i,
    input  logic [TAG_WIDTH-1:0]  x_rd_i,
    output logic                  x_misaligned_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    output logic [31:0]           dm_data_s_o,
    output logic [3:0]            dm_data_select_o,
    output logic                  dm_load_o,
    output logic                  dm_store_o,
    input  logic                  dm_ready_i,
    input  logic                  dm_load_done_i,
    input  logic [31:0]           dm_data_l_i,
    output logic                  w_valid_o,
    output logic [TAG_WIDTH-1:0]  w_rd_o,
    output logic [31:0]           w_rd_value_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] rd;
        logic [2:0]           fun;
        logic [1:0]           lo;
    } meta_t;

    meta_t          fifo_q [OUTSTANDING];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           trap;
    logic           fire;
    logic           push;
    logic           pop;
    logic           is_b;
    logic           is_h;
    logic           is_w;
    meta_t          head;
    logic [7:0]     lb;
    logic [15:0]    lh;
    logic [31:0]    ld_val;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Unsigned variants share the access size of their signed twins.
    assign is_b = (x_fun_i == 3'b000) | (x_fun_i == 3'b100);
    assign is_h = (x_fun_i == 3'b001) | (x_fun_i == 3'b101);
    assign is_w = !is_b & !is_h;

`ifdef URV_LSU_MISALIGN_TRAP_EN
    assign x_misaligned_o = x_req_valid_i & (x_is_load_i | x_is_store_i) &
                            ((is_h & x_addr_i[0]) |
                             (is_w & (x_addr_i[1:0] != 2'b00)));
`else
    assign x_misaligned_o = 1'b0;
`endif
    assign trap = x_misaligned_o;

    assign full  = (count == CW'(OUTSTANDING));
    assign empty = (count == '0);
    assign busy_o = !empty;

    assign x_req_ready_o = dm_ready_i & (!x_is_load_i | !full | dm_load_done_i);
    assign fire = x_req_valid_i & !x_kill_i & x_req_ready_o & !trap;
    assign dm_load_o  = fire & x_is_load_i;
    assign dm_store_o = fire & x_is_store_i;
    assign push = dm_load_o;
    assign pop  = dm_load_done_i & !empty;

    assign dm_addr_o = {x_addr_i[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        dm_data_s_o      = x_data_i;
        dm_data_select_o = 4'b1111;
        unique case (1'b1)
            is_b: begin
                dm_data_s_o      = {4{x_data_i[7:0]}};
                dm_data_select_o = 4'b0001 << x_addr_i[1:0];
            end
            is_h: begin
                dm_data_s_o      = {2{x_data_i[15:0]}};
                dm_data_select_o = x_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign head = fifo_q[rptr];
    assign lb   = dm_data_l_i[{head.lo, 3'b000} +: 8];
    assign lh   = head.lo[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

    always_comb begin
        ld_val = dm_data_l_i;
        case (head.fun)
            3'b000:  ld_val = {{24{lb[7]}}, lb};
            3'b001:  ld_val = {{16{lh[15]}}, lh};
            3'b100:  ld_val = {24'h0, lb};
            3'b101:  ld_val = {16'h0, lh};
            default: ld_val = dm_data_l_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr] <= '{rd: x_rd_i, fun: x_fun_i, lo: x_addr_i[1:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            w_valid_o    <= 1'b0;
            w_rd_o       <= '0;
            w_rd_value_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            w_valid_o <= pop;
            if (pop) begin
                w_rd_o       <= head.rd;
                w_rd_value_o <= ld_val;
            end
            // A response with nothing in flight is a protocol error.
            if (dm_load_done_i & empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_urv_lsu.sv
// tb_urv_lsu: scoreboard bench for urv_lsu (directed cases then random traffic).
// Follows URV_LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_urv_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_req_valid = 1'b0;
    logic        x_req_ready;
    logic        x_kill = 1'b0;
    logic        x_is_load = 1'b0;
    logic        x_is_store = 1'b0;
    logic [2:0]  x_fun = '0;
    logic [31:0] x_addr = '0;
    logic [31:0] x_data = '0;
    logic [4:0]  x_rd = '0;
    logic        x_misaligned;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_data_select;
    logic        dm_load;
    logic        dm_store;
    logic        dm_ready = 1'b1;
    logic        dm_load_done = 1'b0;
    logic [31:0] dm_data_l = '0;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic [31:0] w_rd_value;
    logic        busy;
    logic        err;

    urv_lsu #(.ADDR_WIDTH(32), .OUTSTANDING(2), .TAG_WIDTH(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_req_valid_i(x_req_valid), .x_req_ready_o(x_req_ready),
        .x_kill_i(x_kill), .x_is_load_i(x_is_load), .x_is_store_i(x_is_store),
        .x_fun_i(x_fun), .x_addr_i(x_addr), .x_data_i(x_data), .x_rd_i(x_rd),
        .x_misaligned_o(x_misaligned),
        .dm_addr_o(dm_addr), .dm_data_s_o(dm_data_s),
        .dm_data_select_o(dm_data_select),
        .dm_load_o(dm_load), .dm_store_o(dm_store), .dm_ready_i(dm_ready),
        .dm_load_done_i(dm_load_done), .dm_data_l_i(dm_data_l),
        .w_valid_o(w_valid), .w_rd_o(w_rd), .w_rd_value_o(w_rd_value),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] fun;
        logic [1:0] lo;
    } meta_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } res_t;

    meta_t meta_q[$];
    res_t  exp_q[$];
    bit    err_m = 1'b0;
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] fun,
                                               input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] hh;
        sh = w >> (8 * lo);
        hh = lo[1] ? w[31:16] : w[15:0];
        case (fun)
            3'd0: return {{24{sh[7]}}, sh[7:0]};
            3'd4: return {24'h0, sh[7:0]};
            3'd1: return {{16{hh[15]}}, hh};
            3'd5: return {16'h0, hh};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] sel_model(input logic [2:0] fun,
                                             input logic [1:0] lo);
        case (fun)
            3'd0, 3'd4: return 4'b0001 << lo;
            3'd1, 3'd5: return lo[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] sdata_model(input logic [2:0] fun,
                                                input logic [31:0] d);
        case (fun)
            3'd0, 3'd4: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'd1, 3'd5: return {d[15:0], d[15:0]};
            default:    return d;
        endcase
    endfunction

    function automatic bit mis_model(input bit v, input bit mem,
                                     input logic [2:0] fun,
                                     input logic [31:0] a);
`ifdef URV_LSU_MISALIGN_TRAP_EN
        bit h;
        bit w;
        h = (fun == 3'd1) || (fun == 3'd5);
        w = !(h || fun == 3'd0 || fun == 3'd4);
        return v && mem && ((h && a[0]) || (w && a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // One clock of stimulus: inputs applied at negedge, comb outputs checked.
    task automatic cyc(input bit v, input bit ld, input bit st, input bit kill,
                       input logic [2:0] fun, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd,
                       input bit dmr, input bit done,
                       input logic [31:0] dword);
        int  occ;
        bit  rdy;
        bit  mis;
        bit  fire;
        meta_t m;
        res_t  r;
        @(negedge clk);
        check("busy", busy, 32'(meta_q.size() != 0));
        check("err", err, 32'(err_m));
        x_req_valid  = v;
        x_is_load    = ld;
        x_is_store   = st;
        x_kill       = kill;
        x_fun        = fun;
        x_addr       = addr;
        x_data       = data;
        x_rd         = rd;
        dm_ready     = dmr;
        dm_load_done = done;
        dm_data_l    = dword;
        #1;
        occ  = meta_q.size();
        rdy  = dmr && (!ld || occ < 2 || done);
        mis  = mis_model(v, ld || st, fun, addr);
        fire = v && !kill && rdy && !mis;
        check("ready", x_req_ready, 32'(rdy));
        check("misaligned", x_misaligned, 32'(mis));
        check("dm_load", dm_load, 32'(fire && ld));
        check("dm_store", dm_store, 32'(fire && st));
        if (fire) begin
            check("dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
            check("dm_sel", dm_data_select, 32'(sel_model(fun, addr[1:0])));
            if (st) check("dm_data_s", dm_data_s, sdata_model(fun, data));
        end
        if (done) begin
            if (occ != 0) begin
                m = meta_q.pop_front();
                r.rd  = m.rd;
                r.val = load_model(m.fun, m.lo, dword);
                exp_q.push_back(r);
            end else begin
                err_m = 1'b1;
            end
        end
        if (fire && ld) begin
            m.rd  = rd;
            m.fun = fun;
            m.lo  = addr[1:0];
            meta_q.push_back(m);
        end
    endtask

    task automatic idle(input bit done, input logic [31:0] dword);
        cyc(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1, done, dword);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        x_req_valid = 1'b0;
        x_is_load = 1'b0;
        x_is_store = 1'b0;
        dm_load_done = 1'b0;
        meta_q.delete();
        exp_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_w_valid", w_valid, 32'h0);
        check("rst_w_rd", w_rd, 32'h0);
        check("rst_w_value", w_rd_value, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_err", err, 32'h0);
    endtask

    // Writeback scoreboard: each accepted response must appear one cycle later.
    initial begin
        res_t r;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("w_valid", w_valid, 32'h1);
                check("w_rd", w_rd, 32'(r.rd));
                check("w_value", w_rd_value, r.val);
            end else begin
                check("w_idle", w_valid, 32'h0);
            end
        end
    end

    initial begin
        logic [2:0] ld_funs [5];
        ld_funs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        do_reset();

        // LB at 0x103 then its response
        cyc(1, 1, 0, 0, 3'd0, 32'h103, 32'h0, 5'd1, 1, 0, 32'h0);
        idle(1, 32'h80FF_0000);
        @(posedge clk);
        #3;
        check("lb_value", w_rd_value, 32'hFFFF_FF80);

        // LHU at 0x2
        cyc(1, 1, 0, 0, 3'd5, 32'h2, 32'h0, 5'd4, 1, 0, 32'h0);
        idle(1, 32'h8001_1234);
        @(posedge clk);
        #3;
        check("lhu_value", w_rd_value, 32'h0000_8001);

        // stores: SB, SH, SW
        cyc(1, 0, 1, 0, 3'd0, 32'h1, 32'hAB, 5'd0, 1, 0, 32'h0);
        cyc(1, 0, 1, 0, 3'd1, 32'h12, 32'hCAFE_BEEF, 5'd0, 1, 0, 32'h0);
        cyc(1, 0, 1, 0, 3'd2, 32'h40, 32'h1234_5678, 5'd0, 1, 0, 32'h0);
        idle(0, 32'h0);

        // LH / LBU / LW round trips
        cyc(1, 1, 0, 0, 3'd1, 32'h22, 32'h0, 5'd7, 1, 0, 32'h0);
        cyc(1, 1, 0, 0, 3'd4, 32'h31, 32'h0, 5'd8, 1, 1, 32'h9ABC_0000);
        cyc(1, 1, 0, 0, 3'd2, 32'h44, 32'h0, 5'd9, 1, 1, 32'h0000_F700);
        idle(1, 32'hDEAD_BEEF);
        idle(0, 32'h0);

        // OUTSTANDING=2 back pressure, then retry with a same-cycle response
        cyc(1, 1, 0, 0, 3'd2, 32'h100, 32'h0, 5'd1, 1, 0, 32'h0);
        cyc(1, 1, 0, 0, 3'd2, 32'h104, 32'h0, 5'd2, 1, 0, 32'h0);
        cyc(1, 1, 0, 0, 3'd2, 32'h108, 32'h0, 5'd3, 1, 0, 32'h0);
        cyc(1, 1, 0, 0, 3'd2, 32'h108, 32'h0, 5'd3, 1, 1, 32'h1111_1111);
        idle(1, 32'h2222_2222);
        idle(1, 32'h3333_3333);
        idle(0, 32'h0);

        // killed op and memory not ready
        cyc(1, 1, 0, 1, 3'd2, 32'h10, 32'h0, 5'd5, 1, 0, 32'h0);
        cyc(1, 0, 1, 0, 3'd2, 32'h10, 32'h55, 5'd0, 0, 0, 32'h0);

        // misaligned word load
        cyc(1, 1, 0, 0, 3'd2, 32'h6, 32'h0, 5'd6, 1, 0, 32'h0);
        idle(0, 32'h0);
        if (meta_q.size() != 0) idle(1, 32'h0403_0201);
        idle(0, 32'h0);

        // response with nothing in flight
        idle(1, 32'hFFFF_FFFF);
        idle(0, 32'h0);
        idle(0, 32'h0);

        // reset with two loads in flight, then a stray response
        do_reset();
        cyc(1, 1, 0, 0, 3'd0, 32'h200, 32'h0, 5'd10, 1, 0, 32'h0);
        cyc(1, 1, 0, 0, 3'd0, 32'h201, 32'h0, 5'd11, 1, 0, 32'h0);
        do_reset();
        idle(1, 32'h0);
        idle(0, 32'h0);

        // random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit         v;
            bit         ld;
            bit         st;
            logic [2:0] f;
            v  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 1) == 1);
            st = !ld && ($urandom_range(0, 3) != 0);
            f  = ld ? ld_funs[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            cyc(v, ld, st, ($urandom_range(0, 7) == 0), f, $urandom,
                $urandom, 5'($urandom), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 2) == 0), $urandom);
        end
        idle(0, 32'h0);
        idle(0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
